// File: rtl/addsub_arbiter_pkg.sv
// Shared constants and FSM state type for the adder/subtractor arbiter.
package addsub_arbiter_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int NREQ      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_arbiter_if.sv
// Requester-facing request/response bundle; master = requesters, slave = arbiter.
interface addsub_arbiter_if
  import addsub_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_m;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_d;
  logic                  rsp_carry;
  logic                  rsp_v;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, req_m, rsp_ready,
    input  req_ready, rsp_valid, rsp_d, rsp_carry, rsp_v, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_m, rsp_ready,
    output req_ready, rsp_valid, rsp_d, rsp_carry, rsp_v, busy
  );

endinterface

// File: rtl/addsub_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; last is the index of the previously served requester.
module addsub_arbiter_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Arbitrates two requesters onto one shared adder/subtractor, one op in flight.
//   state | meaning
//   IDLE  | arbitrate; accept winner's operands into dp_*
//   EXEC  | one cycle for the external datapath to settle
//   RESP  | hold rsp_* until the granted requester takes it
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  addsub_arbiter_if.slave    bus,
  output logic [WIDTH-1:0]   dp_a,
  output logic [WIDTH-1:0]   dp_b,
  output logic               dp_m,
  input  logic [WIDTH-1:0]   dp_d,
  input  logic               dp_carry,
  input  logic               dp_v
);

  state_t           state;
  state_t           state_nxt;
  logic [NREQ-1:0]  gnt;
  logic             gnt_idx;
  logic             cur;
  logic             last_grant;
  logic [NREQ-1:0]  rsp_valid;
  logic [WIDTH-1:0] rsp_d;
  logic             rsp_carry;
  logic             rsp_v;
  logic             accept;
  logic             done;

  addsub_arbiter_rr_arbiter2 u_rr_arbiter2 (
    .req  (bus.req_valid),
    .last (last_grant),
    .gnt  (gnt)
  );

  assign gnt_idx = gnt[1];
  assign accept  = (state == IDLE) && (gnt != 2'b00);
  assign done    = (state == RESP) && bus.rsp_ready[cur];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      cur        <= 1'b0;
      dp_a       <= '0;
      dp_b       <= '0;
      dp_m       <= 1'b0;
      rsp_d      <= '0;
      rsp_carry  <= 1'b0;
      rsp_v      <= 1'b0;
      rsp_valid  <= '0;
    end else begin
      if (accept) begin
        cur  <= gnt_idx;
        dp_a <= gnt_idx ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
        dp_b <= gnt_idx ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
        dp_m <= bus.req_m[gnt_idx];
      end
      if (state == EXEC) begin
        rsp_d     <= dp_d;
        rsp_carry <= dp_carry;
        rsp_v     <= dp_v;
        rsp_valid <= cur ? 2'b10 : 2'b01;
      end
      if (done) begin
        rsp_valid  <= '0;
        last_grant <= cur;
      end
    end
  end

  // Gated by reset so a request held during reset is never shown as accepted.
  assign bus.req_ready = ((state == IDLE) && !reset) ? gnt : '0;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_d     = rsp_d;
  assign bus.rsp_carry = rsp_carry;
  assign bus.rsp_v     = rsp_v;
  assign bus.busy      = (state != IDLE);

endmodule
